// File: rtl/dac_i2s_tx.sv
// I2S transmitter for a stereo DAC.
// DSP samples enter a small stereo FIFO; a three-state sequencer produces
// bclk/lrclk/sdata in I2S format (one-bit delay, left word first).
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | serial outputs parked low, FIFO filling, waiting for prefill
//   ST_RUN   | streaming; each frame boundary pops one stereo sample
//   ST_DRAIN | enable dropped; finish the current frame without popping
module dac_i2s_tx #(
   parameter int BCLK_DIV   = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [15:0]                   sample_l,
   input  logic [15:0]                   sample_r,
   input  logic                          sample_valid,
   input  logic                          enable,
   input  logic                          clear_flags,
   output logic                          bclk,
   output logic                          lrclk,
   output logic                          sdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underrun,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [7:0]    DIV_TC   = 8'(BCLK_DIV - 1);
   localparam logic [LW-1:0] PREFILL  = LW'(FIFO_DEPTH / 2);
   localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [7:0]    div;
   logic [4:0]    bit_cnt;
   logic [4:0]    bit_nxt;
   logic [4:0]    sd_idx;
   logic [31:0]   word;

   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic tc;
   logic fall;
   logic wrap;
   logic serial_on;
   logic pop;
   logic fifo_empty;
   logic fifo_full;
   logic pop_ok;
   logic push;
   logic drop;

   // Divider terminal count and the bclk falling / frame-wrap events
   assign tc         = (div == DIV_TC);
   assign fall       = (state != ST_IDLE) && tc && bclk;
   assign wrap       = fall && (bit_cnt == 5'd31);
   assign bit_nxt    = bit_cnt + 5'd1;
   // One-bit I2S delay: slot k carries word[32-k]; slot 0 wraps to word[0]
   assign sd_idx     = 5'd0 - bit_nxt;

   assign fifo_empty = (fifo_level == '0);
   assign fifo_full  = (fifo_level == FULL_LVL);
   // A pop frees a slot in the same cycle, so a full FIFO can still take a push
   assign pop_ok     = pop && !fifo_empty;
   assign push       = sample_valid && (!fifo_full || pop_ok);
   assign drop       = sample_valid && fifo_full && !pop_ok;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (enable && (fifo_level >= PREFILL)) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (enable) begin
               state_nxt = ST_RUN;
            end else if (wrap) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Sequencer outputs: serial engine run request and the frame pop strobe
   always_comb begin
      serial_on = 1'b0;
      pop       = 1'b0;
      case (state)
         ST_RUN: begin
            serial_on = 1'b1;
            pop       = wrap;
         end
         ST_DRAIN: begin
            // re-enabled right on the boundary behaves as RUN; otherwise the
            // boundary parks the outputs instead of starting a new frame
            serial_on = enable || !wrap;
            pop       = wrap && enable;
         end
         default: begin
            serial_on = 1'b0;
            pop       = 1'b0;
         end
      endcase
   end

   // FIFO storage; contents need no reset because the pointers define validity
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= {sample_l, sample_r};
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop_ok})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Frame word: loaded at each popping frame boundary, muted on an empty pop
   always_ff @(posedge clock) begin
      if (reset) begin
         word <= '0;
      end else if (pop) begin
         word <= pop_ok ? mem[rd_ptr] : 32'd0;
      end
   end

   // Bit-clock divider, slot counter and serial outputs (all move on bclk fall)
   always_ff @(posedge clock) begin
      if (reset) begin
         div     <= '0;
         bclk    <= 1'b0;
         lrclk   <= 1'b0;
         sdata   <= 1'b0;
         bit_cnt <= 5'd31;
      end else if (!serial_on) begin
         div     <= '0;
         bclk    <= 1'b0;
         lrclk   <= 1'b0;
         sdata   <= 1'b0;
         bit_cnt <= 5'd31;
      end else if (tc) begin
         div  <= '0;
         bclk <= ~bclk;
         if (bclk) begin
            bit_cnt <= bit_nxt;
            lrclk   <= bit_nxt[4];
            sdata   <= word[sd_idx];
         end
      end else begin
         div <= div + 8'd1;
      end
   end

   // Sticky flags; a same-cycle set beats clear_flags
   always_ff @(posedge clock) begin
      if (reset) begin
         underrun <= 1'b0;
         overflow <= 1'b0;
      end else begin
         underrun <= (pop && fifo_empty) | (underrun & ~clear_flags);
         overflow <= drop | (overflow & ~clear_flags);
      end
   end

endmodule

// File: tb/tb_dac_i2s_tx.sv
// Bench for dac_i2s_tx: directed scenarios plus a randomized stream, with a
// frame scoreboard fed at stimulus time and drained by a serial monitor.
module tb_dac_i2s_tx;

   localparam int BCLK_DIV   = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int FRAME_CLKS = 64 * BCLK_DIV;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] sample_l;
   logic [15:0] sample_r;
   logic        sample_valid;
   logic        enable;
   logic        clear_flags;
   logic        bclk;
   logic        lrclk;
   logic        sdata;
   logic [2:0]  fifo_level;
   logic        underrun;
   logic        overflow;

   dac_i2s_tx #(.BCLK_DIV(BCLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clock        (clock),
      .reset        (reset),
      .sample_l     (sample_l),
      .sample_r     (sample_r),
      .sample_valid (sample_valid),
      .enable       (enable),
      .clear_flags  (clear_flags),
      .bclk         (bclk),
      .lrclk        (lrclk),
      .sdata        (sdata),
      .fifo_level   (fifo_level),
      .underrun     (underrun),
      .overflow     (overflow)
   );

   always #5 clock = ~clock;

   int          total   = 0;
   int          bad     = 0;
   int          nframes = 0;
   bit          mon_en  = 1'b0;
   logic [31:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // one-cycle sample strobe; expected frame enqueued when the push should land
   task automatic push(input logic [15:0] l, input logic [15:0] r, input bit accept);
      sample_l     = l;
      sample_r     = r;
      sample_valid = 1'b1;
      if (accept) exp_q.push_back({l, r});
      @(negedge clock);
      sample_valid = 1'b0;
   endtask

   task automatic do_reset();
      mon_en       = 1'b0;
      reset        = 1'b1;
      enable       = 1'b0;
      sample_valid = 1'b0;
      clear_flags  = 1'b0;
      tick(2);
      reset = 1'b0;
      exp_q.delete();
      tick(1);
   endtask

   task automatic wait_frames(input int target, input int budget);
      int c = 0;
      while (nframes < target && c < budget) begin
         @(negedge clock);
         c++;
      end
      chk("frames_seen", {31'd0, nframes >= target}, 32'd1);
   endtask

   // Serial monitor: deserializes on bclk rises, checks lrclk slot lengths,
   // output stability, and compares each completed frame with the scoreboard.
   initial begin : monitor
      logic        prev_b, prev_lr, cyc_lr, cyc_sd, cyc_b;
      logic [31:0] sh;
      logic [31:0] e;
      int          lo_cnt, hi_cnt;
      bit          seg_ok;
      prev_b = 0; prev_lr = 0; cyc_lr = 0; cyc_sd = 0; cyc_b = 0;
      sh = 0; lo_cnt = 0; hi_cnt = 0; seg_ok = 0;
      forever begin
         @(negedge clock);
         if (reset || !mon_en) begin
            prev_b = 0; prev_lr = 0; sh = 0; lo_cnt = 0; hi_cnt = 0; seg_ok = 0;
            cyc_lr = lrclk; cyc_sd = sdata; cyc_b = bclk;
         end else begin
            if (lrclk !== cyc_lr || sdata !== cyc_sd)
               chk("change_on_fall", {31'd0, cyc_b & ~bclk}, 32'd1);
            if (bclk && !prev_b) begin
               sh = {sh[30:0], sdata};
               if (lrclk && !prev_lr) begin
                  if (seg_ok) chk("lr_low_len", lo_cnt, 16);
                  hi_cnt = 0;
               end
               if (!lrclk && prev_lr) begin
                  chk("lr_high_len", hi_cnt, 16);
                  seg_ok = 1;
                  lo_cnt = 0;
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     chk("frame", sh, e);
                  end
                  nframes++;
               end
               if (lrclk) hi_cnt++;
               else lo_cnt++;
               prev_lr = lrclk;
            end
            prev_b = bclk; cyc_lr = lrclk; cyc_sd = sdata; cyc_b = bclk;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int cur;
      int target;
      reset = 1'b1; sample_l = '0; sample_r = '0; sample_valid = 1'b0;
      enable = 1'b0; clear_flags = 1'b0;

      // reset state
      do_reset();
      chk("rst_bclk", bclk, 0);
      chk("rst_lrclk", lrclk, 0);
      chk("rst_sdata", sdata, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_overflow", overflow, 0);

      // overfill while idle, flag clear priority, ordered playback, underrun
      for (int i = 0; i < 5; i++) push(16'h1000 + 16'(i), 16'h2000 + 16'(i), i < 4);
      chk("ovf_level", fifo_level, 4);
      chk("ovf_flag", overflow, 1);
      chk("ovf_no_underrun", underrun, 0);
      clear_flags = 1'b1;
      push(16'h3333, 16'h4444, 1'b0);
      clear_flags = 1'b0;
      chk("set_wins", overflow, 1);
      clear_flags = 1'b1;
      tick(1);
      clear_flags = 1'b0;
      chk("clear_ovf", overflow, 0);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      enable = 1'b1; mon_en = 1'b1; base = nframes;
      wait_frames(base + 5, 6 * FRAME_CLKS);
      chk("drain_underrun", underrun, 1);
      chk("drain_level", fifo_level, 0);

      // two queued frames, third is muted and raises underrun at its boundary
      do_reset();
      push(16'hBEEF, 16'h1357, 1'b1);
      push(16'h8001, 16'h7FFE, 1'b1);
      exp_q.push_back(32'd0);
      enable = 1'b1; mon_en = 1'b1; base = nframes;
      tick(520);
      chk("ur_before_wrap", underrun, 0);
      chk("ur_level", fifo_level, 0);
      tick(1);
      chk("ur_at_wrap", underrun, 1);
      wait_frames(base + 3, 400);

      // push coincident with pop while full; first bclk rise timing
      do_reset();
      for (int i = 0; i < 4; i++) push(16'hC000 + 16'(i), 16'h0C00 + 16'(i), 1'b1);
      enable = 1'b1; mon_en = 1'b1; base = nframes;
      tick(4);
      chk("bclk_before_rise", bclk, 0);
      tick(1);
      chk("bclk_first_rise", bclk, 1);
      tick(3);
      chk("bclk_pre_pop", bclk, 1);
      push(16'h5A5A, 16'hA5A5, 1'b1);
      chk("cpush_level", fifo_level, 4);
      chk("cpush_overflow", overflow, 0);
      wait_frames(base + 5, 5 * FRAME_CLKS + 100);

      // reference frame, then enable dropped at slot 5 of the next frame
      do_reset();
      push(16'hA5C3, 16'h0F01, 1'b1);
      push(16'h1234, 16'h5679, 1'b1);
      push(16'h0F0F, 16'hF0F0, 1'b1);
      enable = 1'b1; mon_en = 1'b1; base = nframes;
      tick(305);
      enable = 1'b0;
      tick(215);
      chk("drain_last_high", bclk, 1);
      tick(1);
      chk("idle_bclk", bclk, 0);
      chk("idle_lrclk", lrclk, 0);
      chk("idle_sdata", sdata, 0);
      chk("idle_level", fifo_level, 1);
      chk("ref_frame_seen", {31'd0, nframes >= base + 1}, 32'd1);
      tick(20);
      chk("stays_idle", bclk, 0);
      mon_en = 1'b0;

      // reset mid-frame at slot 20
      do_reset();
      push(16'h0000, 16'hFFFF, 1'b0);
      for (int i = 0; i < 4; i++) push(16'h1111, 16'h2222, 1'b0);
      chk("pre_rst_overflow", overflow, 1);
      enable = 1'b1;
      tick(170);
      chk("slot20_lrclk", lrclk, 1);
      chk("slot20_sdata", sdata, 1);
      reset = 1'b1;
      enable = 1'b0;
      tick(1);
      chk("mrst_bclk", bclk, 0);
      chk("mrst_lrclk", lrclk, 0);
      chk("mrst_sdata", sdata, 0);
      chk("mrst_level", fifo_level, 0);
      chk("mrst_underrun", underrun, 0);
      chk("mrst_overflow", overflow, 0);
      reset = 1'b0;
      tick(1);

      // randomized stream, one push per frame period between boundaries
      do_reset();
      push(16'($urandom), 16'($urandom), 1'b1);
      push(16'($urandom), 16'($urandom), 1'b1);
      enable = 1'b1; mon_en = 1'b1; base = nframes;
      cur = 0;
      for (int i = 0; i < 12; i++) begin
         target = 128 + FRAME_CLKS * i + int'($urandom_range(0, 60)) - 30;
         tick(target - cur);
         push(16'($urandom), 16'($urandom), 1'b1);
         cur = target + 1;
      end
      wait_frames(base + 14, 1000);
      chk("rand_overflow", overflow, 0);
      enable = 1'b0;
      mon_en = 1'b0;
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
